// File: rtl/dm_store_buffer.sv
// -----------------------------------------------------------------------------
// dm_store_buffer
// Write buffer between the MEM-stage store/load requests and a single-ported
// data memory. Stores are queued in a small FIFO and drained into DM one word
// per cycle whenever the DM port is not used by a load. Loads that hit a
// buffered word get the youngest buffered data.
//
// Ports
//   clk        : system clock, all state updates on posedge
//   reset      : synchronous active-high clear of the buffer
//   req_store  : MEM stage issues a word store
//   req_load   : MEM stage issues a word load (wins over req_store)
//   req_addr   : byte address of the request (word index is addr[31:2])
//   req_data   : store data
//   req_pc     : PC of the store, carried to DM
//   stall      : store not accepted this cycle (buffer full)
//   fwd_hit    : load matches a buffered entry
//   fwd_data   : data of the youngest matching entry, 0 when no hit
//   dm_store   : DM write enable, head entry drains this cycle
//   dm_addr    : head entry address while draining, else req_addr
//   dm_data    : head entry data
//   dm_pc      : head entry PC
//   count      : current occupancy 0..DEPTH
//   empty      : count == 0
// -----------------------------------------------------------------------------
module dm_store_buffer #(
    parameter int DEPTH = 4,
    parameter int PW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_store,
    input  logic          req_load,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_data,
    input  logic [31:0]   req_pc,
    output logic          stall,
    output logic          fwd_hit,
    output logic [31:0]   fwd_data,
    output logic          dm_store,
    output logic [31:0]   dm_addr,
    output logic [31:0]   dm_data,
    output logic [31:0]   dm_pc,
    output logic [PW:0]   count,
    output logic          empty
);

    localparam logic [PW:0]   FULL_COUNT = (PW + 1)'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE    = {{(PW - 1){1'b0}}, 1'b1};
    localparam logic [PW:0]   CNT_ONE    = {{PW{1'b0}}, 1'b1};

    logic [31:0]   addr_r [DEPTH];
    logic [31:0]   data_r [DEPTH];
    logic [31:0]   pc_r   [DEPTH];
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [PW:0]   count_r;

    logic          store_only_s;
    logic          full_s;
    logic          accept_s;
    logic          drain_s;
    logic          fwd_hit_s;
    logic [31:0]   fwd_data_s;

    // Request decode, drain/enqueue decisions and DM port steering.
    always_comb begin
        // A simultaneous load and store is treated as a load only.
        store_only_s = req_store & ~req_load;
        full_s       = (count_r == FULL_COUNT);
        // A full buffer blocks the store even if the head drains this cycle.
        accept_s     = store_only_s & ~full_s;
        drain_s      = (count_r != {(PW + 1){1'b0}}) & ~req_load;
        stall        = store_only_s & full_s;
        dm_store     = drain_s;
        empty        = (count_r == {(PW + 1){1'b0}});
        count        = count_r;
        dm_data      = data_r[head_r];
        dm_pc        = pc_r[head_r];
        if (drain_s) begin
            dm_addr = addr_r[head_r];
        end else begin
            dm_addr = req_addr;
        end
    end

    // Store-to-load forwarding: walk valid entries oldest to youngest so the
    // last match seen (closest to tail) is the one that wins.
    always_comb begin
        fwd_hit_s  = 1'b0;
        fwd_data_s = 32'h0000_0000;
        for (int k = 0; k < DEPTH; k++) begin
            logic [PW-1:0] idx;
            idx = head_r + PW'(k);
            if (req_load && ((PW + 1)'(k) < count_r)
                && (addr_r[idx][31:2] == req_addr[31:2])) begin
                fwd_hit_s  = 1'b1;
                fwd_data_s = data_r[idx];
            end else begin
                fwd_hit_s  = fwd_hit_s;
                fwd_data_s = fwd_data_s;
            end
        end
        fwd_hit  = fwd_hit_s;
        fwd_data = fwd_data_s;
    end

    // Entry storage; contents are only meaningful while inside the valid window.
    always_ff @(posedge clk) begin
        if (accept_s && !reset) begin
            addr_r[tail_r] <= req_addr;
            data_r[tail_r] <= req_data;
            pc_r[tail_r]   <= req_pc;
        end
    end

    // Head/tail pointers and occupancy counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {(PW + 1){1'b0}};
        end else begin
            if (accept_s) begin
                tail_r <= tail_r + PTR_ONE;
            end
            if (drain_s) begin
                head_r <= head_r + PTR_ONE;
            end
            case ({accept_s, drain_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_store_buffer.sv
module tb_dm_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_store;
    logic        req_load;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [31:0] req_pc;
    logic        stall;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        dm_store;
    logic [31:0] dm_addr;
    logic [31:0] dm_data;
    logic [31:0] dm_pc;
    logic [2:0]  count;
    logic        empty;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dm_store_buffer #(.DEPTH(4), .PW(2)) dut (
        .clk(clk), .reset(reset), .req_store(req_store), .req_load(req_load),
        .req_addr(req_addr), .req_data(req_data), .req_pc(req_pc),
        .stall(stall), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .dm_store(dm_store), .dm_addr(dm_addr), .dm_data(dm_data),
        .dm_pc(dm_pc), .count(count), .empty(empty)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] pc;
    } ent_t;

    typedef struct {
        bit          chk;
        bit          dm_store;
        bit          fwd_hit;
        logic [31:0] fwd_data;
        bit          stall;
        int          count;
        logic [31:0] dm_addr;
    } cyc_t;

    ent_t model_q[$];   // reference buffer contents, oldest first
    ent_t dm_q[$];      // expected DM writes in program order
    cyc_t cyc_q[$];     // expected per-cycle outputs

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // One request cycle: drive inputs, predict outputs, advance the model.
    task automatic step(input bit rst, input bit st, input bit ld,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] p);
        cyc_t e;
        ent_t n;
        int   sz;
        bit   acc;
        @(posedge clk);
        #1;
        reset = rst; req_store = st; req_load = ld;
        req_addr = a; req_data = d; req_pc = p;
        sz          = model_q.size();
        e.chk       = !rst;
        e.dm_store  = (sz > 0) && !ld;
        e.fwd_hit   = 1'b0;
        e.fwd_data  = 32'h0;
        if (ld) begin
            foreach (model_q[i]) begin
                if (model_q[i].addr[31:2] == a[31:2]) begin
                    e.fwd_hit  = 1'b1;
                    e.fwd_data = model_q[i].data;
                end
            end
        end
        e.stall   = st && !ld && (sz == 4);
        e.count   = sz;
        e.dm_addr = e.dm_store ? model_q[0].addr : a;
        cyc_q.push_back(e);
        acc = st && !ld && (sz < 4);
        if (rst) begin
            model_q.delete();
        end else begin
            if (e.dm_store) begin
                dm_q.push_back(model_q[0]);
                void'(model_q.pop_front());
            end
            if (acc) begin
                n.addr = a; n.data = d; n.pc = p;
                model_q.push_back(n);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    // Monitor: compare each cycle's outputs and every DM write as it appears.
    always @(negedge clk) begin
        cyc_t e;
        ent_t w;
        if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            if (e.chk) begin
                check("dm_store", 32'(dm_store), 32'(e.dm_store));
                check("fwd_hit",  32'(fwd_hit),  32'(e.fwd_hit));
                check("fwd_data", fwd_data,      e.fwd_data);
                check("stall",    32'(stall),    32'(e.stall));
                check("count",    32'(count),    32'(e.count));
                check("empty",    32'(empty),    32'(e.count == 0));
                check("dm_addr",  dm_addr,       e.dm_addr);
                if (dm_store === 1'b1) begin
                    if (dm_q.size() == 0) begin
                        check("dm_write_unexpected", 32'd1, 32'd0);
                    end else begin
                        w = dm_q.pop_front();
                        check("dm_wr_addr", dm_addr, w.addr);
                        check("dm_wr_data", dm_data, w.data);
                        check("dm_wr_pc",   dm_pc,   w.pc);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1; req_store = 1'b0; req_load = 1'b0;
        req_addr = 32'h0; req_data = 32'h0; req_pc = 32'h0;

        // 1: reset, single store, drain, empty
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h10, 32'hAAAA_0001, 32'h0040_0000);
        idle(2);

        // 2: store then load held three cycles, then drain
        step(1'b0, 1'b1, 1'b0, 32'h20, 32'h11, 32'h0040_0004);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 32'h0);
        idle(2);

        // 3: two stores to one word, youngest forwarded
        step(1'b0, 1'b1, 1'b0, 32'h30, 32'h1, 32'h0040_0008);
        step(1'b0, 1'b1, 1'b0, 32'h30, 32'h2, 32'h0040_000C);
        step(1'b0, 1'b0, 1'b1, 32'h32, 32'h0, 32'h0);
        idle(3);

        // 4: loads to 0x100 alternating with DEPTH+1 stores, plus a load+store collision
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, 32'h100, 32'h0, 32'h0);
            step(1'b0, 1'b1, 1'b0, 32'h100 + 32'(i * 4), 32'hB000_0000 + 32'(i), 32'h500 + 32'(i));
        end
        step(1'b0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0);
        idle(3);

        // 5: reset with entries pending, old addresses no longer forward
        step(1'b0, 1'b1, 1'b0, 32'h40, 32'hC1, 32'h600);
        step(1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0);
        idle(2);

        // 6: pointer wrap with nine stores to 0x00..0x20
        for (int i = 0; i < 9; i++)
            step(1'b0, 1'b1, 1'b0, 32'(i * 4), 32'h9000_0000 + 32'(i), 32'h700 + 32'(i));
        idle(3);

        // Randomized traffic over a small address window
        for (int i = 0; i < 1500; i++) begin
            bit          rst;
            bit          st;
            bit          ld;
            logic [31:0] a;
            rst = ($urandom_range(0, 99) < 2);
            ld  = ($urandom_range(0, 2) == 0);
            st  = ($urandom_range(0, 1) == 1);
            a   = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            step(rst, st, ld, a, $urandom, $urandom);
        end
        idle(4);

        @(negedge clk);
        #1;
        check("cyc_q_drained", 32'(cyc_q.size()), 32'd0);
        check("dm_q_drained",  32'(dm_q.size()),  32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
